// File: rtl/ring_counter_gen.sv
// Parametrised ring / Johnson counter used as a multi-phase sequencer.
// Illegal states (bad loads or upsets) snap back to the seed and pulse err.
module ring_counter_gen #(
   parameter int WIDTH = 4,
   parameter int MODE  = 0,
   parameter int PW    = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic [PW-1:0]    phase,
   output logic             wrap,
   output logic             err
);

   localparam logic [WIDTH-1:0] SEED = (MODE == 0) ? WIDTH'(1) : '0;

   logic [WIDTH-1:0] nextCount;
   logic             nextWrap;
   logic             nextErr;

   // Ring states are one-hot; Johnson states have at most one 0/1 boundary.
   function automatic logic isLegal(input logic [WIDTH-1:0] c);
      int ones;
      int edges;
      ones  = 0;
      edges = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (c[i]) ones++;
      end
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (c[i] != c[i+1]) edges++;
      end
      if (MODE == 0) return (ones == 1);
      else           return (edges <= 1);
   endfunction

   function automatic logic [WIDTH-1:0] stepCount(input logic [WIDTH-1:0] c, input logic right);
      logic [WIDTH-1:0] s;
      if (MODE == 0) begin
         if (right) s = {c[0], c[WIDTH-1:1]};
         else       s = {c[WIDTH-2:0], c[WIDTH-1]};
      end else begin
         if (right) s = {~c[0], c[WIDTH-1:1]};
         else       s = {c[WIDTH-2:0], ~c[WIDTH-1]};
      end
      return s;
   endfunction

   // Johnson states with bit 0 clear lie in the second half of the period.
   function automatic logic [PW-1:0] phaseOf(input logic [WIDTH-1:0] c);
      int idx;
      int ones;
      idx  = 0;
      ones = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (c[i]) begin
            idx = i;
            ones++;
         end
      end
      if (MODE == 0)                   return PW'(idx);
      else if (c[0] || (c == '0))      return PW'(ones);
      else                             return PW'(2 * WIDTH - ones);
   endfunction

   // Load beats correction, correction beats stepping; wrap only from a real step.
   always_comb begin
      nextCount = count;
      nextWrap  = 1'b0;
      nextErr   = 1'b0;
      if (load) begin
         if (isLegal(load_value)) begin
            nextCount = load_value;
         end else begin
            nextCount = SEED;
            nextErr   = 1'b1;
         end
      end else if (!isLegal(count)) begin
         nextCount = SEED;
         nextErr   = 1'b1;
      end else if (en) begin
         nextCount = stepCount(count, dir);
         nextWrap  = (stepCount(count, dir) == SEED);
      end
   end

   // Phase is derived from the next state so it always matches count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= SEED;
         phase <= '0;
         wrap  <= 1'b0;
         err   <= 1'b0;
      end else begin
         count <= nextCount;
         phase <= phaseOf(nextCount);
         wrap  <= nextWrap;
         err   <= nextErr;
      end
   end

endmodule

// File: tb/tb_ring_counter_gen.sv
// Directed bench for ring_counter_gen: 4-bit ring, 4-bit and 5-bit Johnson instances
// share one clock and reset; every step compares against hand-computed values.
module tb_ring_counter_gen;

   logic clk;
   logic reset;

   logic       r4En, r4Dir, r4Load;
   logic [3:0] r4LoadValue, r4Count;
   logic [2:0] r4Phase;
   logic       r4Wrap, r4Err;

   logic       j4En, j4Dir, j4Load;
   logic [3:0] j4LoadValue, j4Count;
   logic [2:0] j4Phase;
   logic       j4Wrap, j4Err;

   logic       j5En, j5Dir, j5Load;
   logic [4:0] j5LoadValue, j5Count;
   logic [3:0] j5Phase;
   logic       j5Wrap, j5Err;

   int checks;
   int errors;

   localparam logic [3:0] RING_EXP [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
   localparam int         RING_PH  [4]  = '{1, 2, 3, 0};
   localparam logic [3:0] J4_EXP   [8]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                            4'b1110, 4'b1100, 4'b1000, 4'b0000};
   localparam int         J4_PH    [8]  = '{1, 2, 3, 4, 5, 6, 7, 0};
   localparam logic [4:0] J5_EXP   [10] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                                            5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
   localparam int         J5_PH    [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};

   ring_counter_gen #(.WIDTH(4), .MODE(0)) r4 (
      .clk(clk), .reset(reset), .en(r4En), .dir(r4Dir), .load(r4Load),
      .load_value(r4LoadValue), .count(r4Count), .phase(r4Phase), .wrap(r4Wrap), .err(r4Err));

   ring_counter_gen #(.WIDTH(4), .MODE(1)) j4 (
      .clk(clk), .reset(reset), .en(j4En), .dir(j4Dir), .load(j4Load),
      .load_value(j4LoadValue), .count(j4Count), .phase(j4Phase), .wrap(j4Wrap), .err(j4Err));

   ring_counter_gen #(.WIDTH(5), .MODE(1)) j5 (
      .clk(clk), .reset(reset), .en(j5En), .dir(j5Dir), .load(j5Load),
      .load_value(j5LoadValue), .count(j5Count), .phase(j5Phase), .wrap(j5Wrap), .err(j5Err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic applyStimulus();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag,
                              input logic [31:0] cnt, input logic [31:0] expCnt,
                              input logic [7:0] ph, input int expPh,
                              input logic wr, input logic expWr,
                              input logic er, input logic expEr);
      checks++;
      assert (cnt === expCnt && ph === 8'(expPh) && wr === expWr && er === expEr)
      else begin
         errors++;
         $error("[TB] FAIL %s: got count=%h phase=%0d wrap=%b err=%b, expected count=%h phase=%0d wrap=%b err=%b",
                tag, cnt, ph, wr, er, expCnt, expPh, expWr, expEr);
      end
   endtask

   task automatic checkR4(input string tag, input logic [3:0] c, input int p, input logic w, input logic e);
      checkOutput(tag, 32'(r4Count), 32'(c), 8'(r4Phase), p, r4Wrap, w, r4Err, e);
   endtask

   task automatic checkJ4(input string tag, input logic [3:0] c, input int p, input logic w, input logic e);
      checkOutput(tag, 32'(j4Count), 32'(c), 8'(j4Phase), p, j4Wrap, w, j4Err, e);
   endtask

   task automatic checkJ5(input string tag, input logic [4:0] c, input int p, input logic w, input logic e);
      checkOutput(tag, 32'(j5Count), 32'(c), 8'(j5Phase), p, j5Wrap, w, j5Err, e);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      r4En = 1'b0; r4Dir = 1'b0; r4Load = 1'b0; r4LoadValue = 4'b0000;
      j4En = 1'b0; j4Dir = 1'b0; j4Load = 1'b0; j4LoadValue = 4'b0000;
      j5En = 1'b0; j5Dir = 1'b0; j5Load = 1'b0; j5LoadValue = 5'b00000;

      #12;
      checkR4("reset_r4", 4'b0001, 0, 1'b0, 1'b0);
      checkJ4("reset_j4", 4'b0000, 0, 1'b0, 1'b0);
      checkJ5("reset_j5", 5'b00000, 0, 1'b0, 1'b0);
      applyStimulus();
      reset = 1'b0;

      // Ring left walk, wrap on the return to 0001
      r4En = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkR4($sformatf("ring_left_%0d", i), RING_EXP[i], RING_PH[i], i == 3, 1'b0);
      end
      r4En = 1'b0;

      // Johnson left over the full period, then a single right step
      j4En = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus();
         checkJ4($sformatf("johnson_left_%0d", i), J4_EXP[i], J4_PH[i], i == 7, 1'b0);
      end
      j4Dir = 1'b1;
      applyStimulus();
      checkJ4("johnson_right", 4'b1000, 7, 1'b0, 1'b0);
      j4En = 1'b0;
      applyStimulus();
      checkJ4("johnson_hold_dir", 4'b1000, 7, 1'b0, 1'b0);
      j4Dir = 1'b0;

      // Legal and illegal loads
      r4Load = 1'b1; r4LoadValue = 4'b0100;
      applyStimulus();
      checkR4("load_legal", 4'b0100, 2, 1'b0, 1'b0);
      r4LoadValue = 4'b0110;
      applyStimulus();
      checkR4("load_illegal", 4'b0001, 0, 1'b0, 1'b1);
      r4Load = 1'b0;
      applyStimulus();
      checkR4("err_clears", 4'b0001, 0, 1'b0, 1'b0);

      // Upset into an illegal Johnson state is corrected without en
      j4.count = 4'b0101;
      applyStimulus();
      checkJ4("upset_correct", 4'b0000, 0, 1'b0, 1'b1);
      applyStimulus();
      checkJ4("upset_err_clears", 4'b0000, 0, 1'b0, 1'b0);

      // Load wins over en; then right step onto seed and instant direction change
      r4Load = 1'b1; r4LoadValue = 4'b1000;
      applyStimulus();
      checkR4("load_1000", 4'b1000, 3, 1'b0, 1'b0);
      r4LoadValue = 4'b0010; r4En = 1'b1;
      applyStimulus();
      checkR4("load_over_en", 4'b0010, 1, 1'b0, 1'b0);
      r4Load = 1'b0; r4Dir = 1'b1;
      applyStimulus();
      checkR4("ring_right_wrap", 4'b0001, 0, 1'b1, 1'b0);
      r4Dir = 1'b0;
      applyStimulus();
      checkR4("ring_dir_change", 4'b0010, 1, 1'b0, 1'b0);
      r4En = 1'b0;

      // Asynchronous reset between edges
      r4Load = 1'b1; r4LoadValue = 4'b0100;
      applyStimulus();
      r4Load = 1'b0;
      checkR4("pre_async_reset", 4'b0100, 2, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      checkR4("async_reset_r4", 4'b0001, 0, 1'b0, 1'b0);
      applyStimulus();
      reset = 1'b0;

      // 5-bit Johnson full period of 10
      j5En = 1'b1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus();
         checkJ5($sformatf("johnson5_left_%0d", i), J5_EXP[i], J5_PH[i], i == 9, 1'b0);
      end
      j5Dir = 1'b1;
      applyStimulus();
      checkJ5("johnson5_right", 5'b10000, 9, 1'b0, 1'b0);
      applyStimulus();
      checkJ5("johnson5_right2", 5'b11000, 8, 1'b0, 1'b0);
      j5En = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
